// File: rtl/color_fx_pipe.sv
// -----------------------------------------------------------------------------
// color_fx_pipe
//   Fully pipelined colour-effect stage for the ISP path. Accepts one {R,G,B}
//   pixel per clock with VGA timing, applies one of ten effects and emits the
//   result exactly 3 cycles later with the timing signals delayed to match.
//   The effect mode is latched only at frame start (v_sync going active), so a
//   frame is never processed with two different effects.
//
// Parameters
//   CW              bits per colour channel (pixel = 3*CW bits, {R,G,B})
//   SYNC_ACTIVE_LOW 1: h_sync/v_sync are active-low (idle/reset level is 1)
//
// Ports
//   clk             pixel clock
//   reset           synchronous active-high reset
//   mode_sel[3:0]   requested effect (taken at the next frame start)
//   level[CW-1:0]   effect amount / threshold, sampled every cycle
//   i_valid         input pixel valid
//   i_rgb           input pixel {R,G,B}
//   i_h_sync        horizontal sync
//   i_v_sync        vertical sync
//   i_de            display enable
//   o_valid         i_valid delayed 3 cycles
//   o_rgb           processed pixel (zero while delayed de is low)
//   o_h_sync        i_h_sync delayed 3 cycles
//   o_v_sync        i_v_sync delayed 3 cycles
//   o_de            i_de delayed 3 cycles
//   o_mode[3:0]     currently active effect
//
// Optional build macro COLOR_FX_STATS_EN adds:
//   o_luma_sum[CW+18:0]  saturating sum of Y over the previous frame's
//                        valid & de pixels, updated at each frame start
//   o_stats_valid        one-cycle pulse when o_luma_sum is updated
// -----------------------------------------------------------------------------
module color_fx_pipe #(
    parameter int CW              = 4,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      mode_sel,
    input  logic [CW-1:0]   level,
    input  logic            i_valid,
    input  logic [3*CW-1:0] i_rgb,
    input  logic            i_h_sync,
    input  logic            i_v_sync,
    input  logic            i_de,
    output logic            o_valid,
    output logic [3*CW-1:0] o_rgb,
    output logic            o_h_sync,
    output logic            o_v_sync,
    output logic            o_de,
    output logic [3:0]      o_mode
`ifdef COLOR_FX_STATS_EN
    ,
    output logic [CW+18:0]  o_luma_sum,
    output logic            o_stats_valid
`endif
);

    typedef enum logic [3:0] {
        FX_PASS     = 4'd0,
        FX_RED      = 4'd1,
        FX_GREEN    = 4'd2,
        FX_BLUE     = 4'd3,
        FX_BRIGHTEN = 4'd4,
        FX_DARKEN   = 4'd5,
        FX_GRAY     = 4'd6,
        FX_INVERT   = 4'd7,
        FX_THRESH   = 4'd8,
        FX_CONTRAST = 4'd9
    } fx_mode_t;

    localparam logic          SYNC_IDLE = SYNC_ACTIVE_LOW;
    localparam logic [CW-1:0] C_MAX     = '1;
    localparam logic [CW-1:0] C_MID     = {1'b1, {(CW-1){1'b0}}};

    // ------------------------------------------------------------------
    // Per-channel effect helpers
    // ------------------------------------------------------------------
    function automatic logic [CW-1:0] f_brighten(input logic [CW-1:0] c,
                                                 input logic [CW-1:0] l);
        logic [CW:0] s;
        s = {1'b0, c} + {1'b0, l};
        return s[CW] ? C_MAX : s[CW-1:0];
    endfunction

    function automatic logic [CW-1:0] f_darken(input logic [CW-1:0] c,
                                               input logic [CW-1:0] l);
        return (c > l) ? (c - l) : '0;
    endfunction

    // 2c - MID evaluated signed in CW+2 bits, then clamped to [0, MAX]
    function automatic logic [CW-1:0] f_contrast(input logic [CW-1:0] c);
        logic signed [CW+1:0] t;
        logic [CW-1:0]        res;
        t = $signed({1'b0, c, 1'b0}) - $signed({2'b00, C_MID});
        if (t[CW+1])
            res = '0;
        else if (t > $signed({2'b00, C_MAX}))
            res = C_MAX;
        else
            res = t[CW-1:0];
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Frame-start detection and mode latch
    // ------------------------------------------------------------------
    logic       r_vs_prev;
    logic [3:0] r_active_mode;
    logic       w_frame_start;
    logic [3:0] w_mode_eff;

    assign w_frame_start = (r_vs_prev == SYNC_IDLE) && (i_v_sync != SYNC_IDLE);
    // The pixel arriving with the frame-start event already belongs to the
    // new frame, so it takes the newly requested mode.
    assign w_mode_eff    = w_frame_start ? mode_sel : r_active_mode;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vs_prev     <= SYNC_IDLE;
            r_active_mode <= '0;
        end else begin
            r_vs_prev <= i_v_sync;
            if (w_frame_start)
                r_active_mode <= mode_sel;
        end
    end

    // ------------------------------------------------------------------
    // Timing delay lines (3 deep, index 1 aligns with S2, index 2 is output)
    // ------------------------------------------------------------------
    logic [2:0] r_vld_sr;
    logic [2:0] r_de_sr;
    logic [2:0] r_hs_sr;
    logic [2:0] r_vs_sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_sr <= '0;
            r_de_sr  <= '0;
            r_hs_sr  <= {3{SYNC_IDLE}};
            r_vs_sr  <= {3{SYNC_IDLE}};
        end else begin
            r_vld_sr <= {r_vld_sr[1:0], i_valid};
            r_de_sr  <= {r_de_sr[1:0],  i_de};
            r_hs_sr  <= {r_hs_sr[1:0],  i_h_sync};
            r_vs_sr  <= {r_vs_sr[1:0],  i_v_sync};
        end
    end

    // ------------------------------------------------------------------
    // S1: register pixel, level, mode; compute luma products
    // ------------------------------------------------------------------
    logic [CW-1:0] w_in_r, w_in_g, w_in_b;
    logic [CW+7:0] w_pr, w_pg, w_pb;

    assign w_in_r = i_rgb[3*CW-1:2*CW];
    assign w_in_g = i_rgb[2*CW-1:CW];
    assign w_in_b = i_rgb[CW-1:0];
    assign w_pr   = (CW+8)'(w_in_r) * (CW+8)'(77);
    assign w_pg   = (CW+8)'(w_in_g) * (CW+8)'(150);
    assign w_pb   = (CW+8)'(w_in_b) * (CW+8)'(29);

    logic [CW-1:0] r_s1_r, r_s1_g, r_s1_b, r_s1_level;
    logic [CW+7:0] r_s1_pr, r_s1_pg, r_s1_pb;
    logic [3:0]    r_s1_mode;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_r     <= '0;
            r_s1_g     <= '0;
            r_s1_b     <= '0;
            r_s1_level <= '0;
            r_s1_pr    <= '0;
            r_s1_pg    <= '0;
            r_s1_pb    <= '0;
            r_s1_mode  <= '0;
        end else begin
            r_s1_r     <= w_in_r;
            r_s1_g     <= w_in_g;
            r_s1_b     <= w_in_b;
            r_s1_level <= level;
            r_s1_pr    <= w_pr;
            r_s1_pg    <= w_pg;
            r_s1_pb    <= w_pb;
            r_s1_mode  <= w_mode_eff;
        end
    end

    // ------------------------------------------------------------------
    // S2: luma sum >> 8. Weights total 256, so the sum never exceeds
    // MAX*256 and fits in CW+8 bits.
    // ------------------------------------------------------------------
    logic [CW+7:0] w_gsum;
    assign w_gsum = r_s1_pr + r_s1_pg + r_s1_pb;

    logic [CW-1:0] r_s2_r, r_s2_g, r_s2_b, r_s2_y, r_s2_level;
    logic [3:0]    r_s2_mode;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_r     <= '0;
            r_s2_g     <= '0;
            r_s2_b     <= '0;
            r_s2_y     <= '0;
            r_s2_level <= '0;
            r_s2_mode  <= '0;
        end else begin
            r_s2_r     <= r_s1_r;
            r_s2_g     <= r_s1_g;
            r_s2_b     <= r_s1_b;
            r_s2_y     <= CW'(w_gsum >> 8);
            r_s2_level <= r_s1_level;
            r_s2_mode  <= r_s1_mode;
        end
    end

    // ------------------------------------------------------------------
    // S3: effect mux, saturation, blanking
    // ------------------------------------------------------------------
    logic [CW-1:0] w_fx_r, w_fx_g, w_fx_b;

    always_comb begin
        w_fx_r = r_s2_r;
        w_fx_g = r_s2_g;
        w_fx_b = r_s2_b;
        case (r_s2_mode)
            FX_RED: begin
                w_fx_g = '0;
                w_fx_b = '0;
            end
            FX_GREEN: begin
                w_fx_r = '0;
                w_fx_b = '0;
            end
            FX_BLUE: begin
                w_fx_r = '0;
                w_fx_g = '0;
            end
            FX_BRIGHTEN: begin
                w_fx_r = f_brighten(r_s2_r, r_s2_level);
                w_fx_g = f_brighten(r_s2_g, r_s2_level);
                w_fx_b = f_brighten(r_s2_b, r_s2_level);
            end
            FX_DARKEN: begin
                w_fx_r = f_darken(r_s2_r, r_s2_level);
                w_fx_g = f_darken(r_s2_g, r_s2_level);
                w_fx_b = f_darken(r_s2_b, r_s2_level);
            end
            FX_GRAY: begin
                w_fx_r = r_s2_y;
                w_fx_g = r_s2_y;
                w_fx_b = r_s2_y;
            end
            FX_INVERT: begin
                w_fx_r = C_MAX - r_s2_r;
                w_fx_g = C_MAX - r_s2_g;
                w_fx_b = C_MAX - r_s2_b;
            end
            FX_THRESH: begin
                w_fx_r = (r_s2_y >= r_s2_level) ? C_MAX : '0;
                w_fx_g = w_fx_r;
                w_fx_b = w_fx_r;
            end
            FX_CONTRAST: begin
                w_fx_r = f_contrast(r_s2_r);
                w_fx_g = f_contrast(r_s2_g);
                w_fx_b = f_contrast(r_s2_b);
            end
            default: ;  // 0 and 10-15: passthrough
        endcase
        // Blank outside the active area, using de aligned with S2 data
        if (!r_de_sr[1]) begin
            w_fx_r = '0;
            w_fx_g = '0;
            w_fx_b = '0;
        end
    end

    logic [3*CW-1:0] r_out_rgb;

    always_ff @(posedge clk) begin
        if (reset)
            r_out_rgb <= '0;
        else
            r_out_rgb <= {w_fx_r, w_fx_g, w_fx_b};
    end

    assign o_rgb    = r_out_rgb;
    assign o_valid  = r_vld_sr[2];
    assign o_de     = r_de_sr[2];
    assign o_h_sync = r_hs_sr[2];
    assign o_v_sync = r_vs_sr[2];
    assign o_mode   = r_active_mode;

`ifdef COLOR_FX_STATS_EN
    // ------------------------------------------------------------------
    // Frame luma statistics. The frame-start flag travels with its pixel
    // so the swap happens at S3 alignment; that pixel seeds the new sum.
    // ------------------------------------------------------------------
    logic            r_s1_fs, r_s2_fs;
    logic [CW+18:0]  r_acc, r_luma_sum;
    logic            r_stats_vld;
    logic [CW+18:0]  w_acc_base, w_y_add, w_acc_sat;
    logic [CW+19:0]  w_acc_next;

    assign w_acc_base = r_s2_fs ? '0 : r_acc;
    assign w_y_add    = (r_vld_sr[1] & r_de_sr[1]) ? (CW+19)'(r_s2_y) : '0;
    assign w_acc_next = {1'b0, w_acc_base} + {1'b0, w_y_add};
    assign w_acc_sat  = w_acc_next[CW+19] ? '1 : w_acc_next[CW+18:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_fs     <= 1'b0;
            r_s2_fs     <= 1'b0;
            r_acc       <= '0;
            r_luma_sum  <= '0;
            r_stats_vld <= 1'b0;
        end else begin
            r_s1_fs     <= w_frame_start;
            r_s2_fs     <= r_s1_fs;
            r_acc       <= w_acc_sat;
            r_stats_vld <= r_s2_fs;
            if (r_s2_fs)
                r_luma_sum <= r_acc;
        end
    end

    assign o_luma_sum    = r_luma_sum;
    assign o_stats_valid = r_stats_vld;
`endif

endmodule

// File: tb/tb_color_fx_pipe.sv
// -----------------------------------------------------------------------------
// tb_color_fx_pipe
//   Self-checking bench for color_fx_pipe (CW=4, active-low syncs). A
//   behavioural model computes every pixel's result from the effect rules
//   with integer arithmetic and queues it; outputs are compared 3 cycles
//   later. Directed scenarios check the documented example values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_color_fx_pipe;

    localparam int   CW   = 4;
    localparam int   PW   = 3 * CW;
    localparam int   MAXV = (1 << CW) - 1;
    localparam int   MIDV = 1 << (CW - 1);
    localparam logic IDLE = 1'b1;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    mode_sel;
    logic [CW-1:0] level;
    logic          i_valid;
    logic [PW-1:0] i_rgb;
    logic          i_h_sync, i_v_sync, i_de;
    logic          o_valid;
    logic [PW-1:0] o_rgb;
    logic          o_h_sync, o_v_sync, o_de;
    logic [3:0]    o_mode;
`ifdef COLOR_FX_STATS_EN
    logic [CW+18:0] o_luma_sum;
    logic           o_stats_valid;
`endif

    color_fx_pipe #(.CW(CW), .SYNC_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset(reset), .mode_sel(mode_sel), .level(level),
        .i_valid(i_valid), .i_rgb(i_rgb), .i_h_sync(i_h_sync),
        .i_v_sync(i_v_sync), .i_de(i_de), .o_valid(o_valid), .o_rgb(o_rgb),
        .o_h_sync(o_h_sync), .o_v_sync(o_v_sync), .o_de(o_de), .o_mode(o_mode)
`ifdef COLOR_FX_STATS_EN
        , .o_luma_sum(o_luma_sum), .o_stats_valid(o_stats_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [PW-1:0] rgb;
        logic          hs, vs, de;
        logic          sv;
        longint        luma;
    } exp_t;

    exp_t   q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     m_mode;
    logic   m_prev_vs;
    longint m_acc;

    // ---------------- behavioural model ----------------
    function automatic int luma_of(logic [PW-1:0] px);
        int r, g, b;
        r = int'(px[PW-1:2*CW]);
        g = int'(px[2*CW-1:CW]);
        b = int'(px[CW-1:0]);
        return (r * 77 + g * 150 + b * 29) / 256;
    endfunction

    function automatic logic [PW-1:0] model_px(int mode, int lvl, logic [PW-1:0] px, logic de);
        int c[3];
        int o[3];
        int y, v;
        c[0] = int'(px[PW-1:2*CW]);
        c[1] = int'(px[2*CW-1:CW]);
        c[2] = int'(px[CW-1:0]);
        y = luma_of(px);
        for (int k = 0; k < 3; k++) begin
            case (mode)
                1: o[k] = (k == 0) ? c[k] : 0;
                2: o[k] = (k == 1) ? c[k] : 0;
                3: o[k] = (k == 2) ? c[k] : 0;
                4: o[k] = (c[k] + lvl > MAXV) ? MAXV : c[k] + lvl;
                5: o[k] = (c[k] > lvl) ? c[k] - lvl : 0;
                6: o[k] = y;
                7: o[k] = MAXV - c[k];
                8: o[k] = (y >= lvl) ? MAXV : 0;
                9: begin
                    v = 2 * c[k] - MIDV;
                    o[k] = (v < 0) ? 0 : ((v > MAXV) ? MAXV : v);
                end
                default: o[k] = c[k];
            endcase
            if (!de) o[k] = 0;
        end
        return PW'((o[0] << (2 * CW)) | (o[1] << CW) | o[2]);
    endfunction

    task automatic reset_model();
        exp_t idle;
        idle.valid = 1'b0; idle.rgb = '0; idle.hs = IDLE; idle.vs = IDLE;
        idle.de = 1'b0; idle.sv = 1'b0; idle.luma = 0;
        q.delete();
        q.push_back(idle);
        q.push_back(idle);
        m_mode    = 0;
        m_prev_vs = IDLE;
        m_acc     = 0;
    endtask

    // Apply current inputs for one clock; returns the expectation for the
    // values now visible on the outputs.
    task automatic step(output exp_t e);
        exp_t   n;
        logic   ev;
        longint lim;
        lim = (longint'(1) << (CW + 19)) - 1;
        ev = (m_prev_vs == IDLE) && (i_v_sync != IDLE);
        m_prev_vs = i_v_sync;
        if (ev) m_mode = int'(mode_sel);
        n.valid = i_valid;
        n.rgb   = model_px(m_mode, int'(level), i_rgb, i_de);
        n.hs    = i_h_sync;
        n.vs    = i_v_sync;
        n.de    = i_de;
        n.sv    = ev;
        n.luma  = m_acc;
        if (ev) m_acc = 0;
        if (i_valid && i_de) begin
            m_acc = m_acc + luma_of(i_rgb);
            if (m_acc > lim) m_acc = lim;
        end
        q.push_back(n);
        @(posedge clk);
        #1;
        e = q.pop_front();
    endtask

    task automatic set_in(logic v, logic [PW-1:0] px, logic hs, logic vs, logic de);
        i_valid = v; i_rgb = px; i_h_sync = hs; i_v_sync = vs; i_de = de;
    endtask

    task automatic frame_start(logic [3:0] m);
        exp_t e;
        mode_sel = m;
        set_in(1'b0, '0, IDLE, ~IDLE, 1'b0);
        step(e);
        step(e);
        set_in(1'b0, '0, IDLE, IDLE, 1'b0);
        step(e);
        step(e);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        exp_t e;
        mode_sel = 4'd0;
        level    = '0;
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, PW'($urandom), 1'($urandom), IDLE, 1'b1);
            step(e);
        end
        reset = 1'b1;
        set_in(1'b1, 12'hABC, 1'b0, IDLE, 1'b1);
        @(posedge clk);
        #1;
        n_checks++; if (o_rgb !== '0)     begin n_fail++; $display("FAIL reset_rgb: got %h expected 000", o_rgb); end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        n_checks++; if (o_mode !== 4'd0)  begin n_fail++; $display("FAIL reset_mode: got %0d expected 0", o_mode); end
        n_checks++; if (o_h_sync !== 1'b1) begin n_fail++; $display("FAIL reset_hsync: got %b expected 1", o_h_sync); end
        n_checks++; if (o_v_sync !== 1'b1) begin n_fail++; $display("FAIL reset_vsync: got %b expected 1", o_v_sync); end
        n_checks++; if (o_de !== 1'b0)    begin n_fail++; $display("FAIL reset_de: got %b expected 0", o_de); end
`ifdef COLOR_FX_STATS_EN
        n_checks++; if (o_luma_sum !== '0 || o_stats_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_stats: got sum=%0d sv=%b expected 0/0", o_luma_sum, o_stats_valid);
        end
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        reset_model();
        // first post-reset pixel must appear exactly 3 cycles later
        for (int i = 0; i < 3; i++) begin
            if (i == 0) set_in(1'b1, 12'h5A3, IDLE, IDLE, 1'b1);
            else        set_in(1'b0, '0, IDLE, IDLE, 1'b0);
            step(e);
            n_checks++;
            if (o_valid !== (i == 2)) begin
                n_fail++; $display("FAIL reset_latency step %0d: o_valid got %b expected %b", i, o_valid, (i == 2));
            end
        end
        n_checks++; if (o_rgb !== 12'h5A3) begin n_fail++; $display("FAIL reset_first_pixel: got %h expected 5a3", o_rgb); end
    endtask

    task automatic test_brighten();
        exp_t e;
        frame_start(4'd4);
        level = 4'd5;
        set_in(1'b1, 12'hC3A, IDLE, IDLE, 1'b1);
        step(e);
        set_in(1'b0, '0, IDLE, IDLE, 1'b0);
        step(e);
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL brighten_early: o_valid got %b expected 0", o_valid); end
        step(e);
        n_checks++; if (o_rgb !== 12'hF8F || o_valid !== 1'b1) begin
            n_fail++; $display("FAIL brighten: got rgb=%h v=%b expected rgb=f8f v=1", o_rgb, o_valid);
        end
        n_checks++; if (o_mode !== 4'd4) begin n_fail++; $display("FAIL brighten_mode: got %0d expected 4", o_mode); end
    endtask

    task automatic test_gray();
        exp_t          e;
        logic [PW-1:0] px[3];
        logic [PW-1:0] ex[3];
        px[0] = 12'hF00; ex[0] = 12'h444;
        px[1] = 12'hFFF; ex[1] = 12'hFFF;
        px[2] = 12'h000; ex[2] = 12'h000;
        frame_start(4'd6);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) set_in(1'b1, px[i], IDLE, IDLE, 1'b1);
            else       set_in(1'b0, '0, IDLE, IDLE, 1'b0);
            step(e);
            if (i >= 2) begin
                n_checks++;
                if (o_rgb !== ex[i-2] || o_valid !== 1'b1) begin
                    n_fail++; $display("FAIL gray[%0d]: got rgb=%h v=%b expected rgb=%h v=1", i - 2, o_rgb, o_valid, ex[i-2]);
                end
            end
        end
    endtask

    task automatic test_mode_change();
        exp_t e;
        frame_start(4'd0);
        mode_sel = 4'd7;
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, 12'h123, 1'(i == 3 ? 0 : 1), IDLE, 1'b1);
            step(e);
            if (i >= 2) begin
                n_checks++;
                if (o_rgb !== 12'h123 || o_mode !== 4'd0) begin
                    n_fail++; $display("FAIL midframe_hold: got rgb=%h mode=%0d expected rgb=123 mode=0", o_rgb, o_mode);
                end
            end
        end
        frame_start(4'd7);
        n_checks++; if (o_mode !== 4'd7) begin n_fail++; $display("FAIL new_frame_mode: got %0d expected 7", o_mode); end
        set_in(1'b1, 12'h123, IDLE, IDLE, 1'b1);
        for (int i = 0; i < 3; i++) step(e);
        n_checks++; if (o_rgb !== 12'hEDC) begin n_fail++; $display("FAIL invert: got %h expected edc", o_rgb); end
    endtask

    task automatic test_contrast_thresh();
        exp_t e;
        frame_start(4'd9);
        set_in(1'b1, 12'h3AE, IDLE, IDLE, 1'b1);
        for (int i = 0; i < 3; i++) step(e);
        n_checks++; if (o_rgb !== 12'h0CF) begin n_fail++; $display("FAIL contrast: got %h expected 0cf", o_rgb); end
        frame_start(4'd8);
        level = 4'd4;
        set_in(1'b1, 12'hF00, IDLE, IDLE, 1'b1);
        step(e);
        set_in(1'b1, 12'h300, IDLE, IDLE, 1'b1);
        step(e);
        step(e);
        n_checks++; if (o_rgb !== 12'hFFF) begin n_fail++; $display("FAIL thresh_hi: got %h expected fff", o_rgb); end
        step(e);
        n_checks++; if (o_rgb !== 12'h000) begin n_fail++; $display("FAIL thresh_lo: got %h expected 000", o_rgb); end
    endtask

    task automatic test_blank_align();
        exp_t e;
        logic [2:0] hist[3];
        frame_start(4'd0);
        set_in(1'b1, 12'hFFF, IDLE, IDLE, 1'b0);
        for (int i = 0; i < 3; i++) step(e);
        n_checks++; if (o_rgb !== '0 || o_valid !== 1'b1 || o_de !== 1'b0) begin
            n_fail++; $display("FAIL blanking: got rgb=%h v=%b de=%b expected rgb=000 v=1 de=0", o_rgb, o_valid, o_de);
        end
        mode_sel = 4'd0;
        for (int i = 0; i < 40; i++) begin
            set_in(1'b1, 12'hFFF, 1'($urandom), 1'($urandom), 1'($urandom));
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = {i_h_sync, i_v_sync, i_de};
            step(e);
            if (i >= 2) begin
                n_checks++;
                if ({o_h_sync, o_v_sync, o_de} !== hist[2]) begin
                    n_fail++; $display("FAIL sync_align %0d: got hs/vs/de=%b expected %b", i, {o_h_sync, o_v_sync, o_de}, hist[2]);
                end
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        for (int i = 0; i < 1500; i++) begin
            mode_sel = 4'($urandom);
            level    = CW'($urandom);
            set_in(1'($urandom_range(0, 3) != 0), PW'($urandom), 1'($urandom),
                   ($urandom_range(0, 39) == 0) ? ~IDLE : IDLE, 1'($urandom_range(0, 3) != 0));
            step(e);
            n_checks++;
            if ({o_valid, o_rgb, o_h_sync, o_v_sync, o_de} !== {e.valid, e.rgb, e.hs, e.vs, e.de}) begin
                n_fail++;
                $display("FAIL random_out %0d: got v=%b rgb=%h hs=%b vs=%b de=%b expected v=%b rgb=%h hs=%b vs=%b de=%b",
                         i, o_valid, o_rgb, o_h_sync, o_v_sync, o_de, e.valid, e.rgb, e.hs, e.vs, e.de);
            end
            n_checks++;
            if (o_mode !== 4'(m_mode)) begin
                n_fail++; $display("FAIL random_mode %0d: got %0d expected %0d", i, o_mode, m_mode);
            end
`ifdef COLOR_FX_STATS_EN
            n_checks++;
            if (o_stats_valid !== e.sv || (e.sv && o_luma_sum !== (CW+19)'(e.luma))) begin
                n_fail++; $display("FAIL random_stats %0d: got sv=%b sum=%0d expected sv=%b sum=%0d",
                                   i, o_stats_valid, o_luma_sum, e.sv, e.luma);
            end
`endif
        end
    endtask

`ifdef COLOR_FX_STATS_EN
    task automatic test_stats();
        exp_t e;
        int   pulses;
        frame_start(4'd0);
        set_in(1'b1, 12'hFFF, IDLE, IDLE, 1'b1);
        for (int i = 0; i < 4; i++) step(e);
        set_in(1'b0, '0, IDLE, IDLE, 1'b0);
        step(e);
        pulses = 0;
        set_in(1'b0, '0, IDLE, ~IDLE, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) set_in(1'b0, '0, IDLE, IDLE, 1'b0);
            step(e);
            if (o_stats_valid === 1'b1) begin
                pulses++;
                n_checks++;
                if (o_luma_sum !== 23'd60) begin n_fail++; $display("FAIL stats_sum: got %0d expected 60", o_luma_sum); end
            end
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL stats_pulse: got %0d pulses expected 1", pulses); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        mode_sel = '0;
        level = '0;
        set_in(1'b0, '0, IDLE, IDLE, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        reset_model();
        test_reset();
        test_brighten();
        test_gray();
        test_mode_change();
        test_contrast_thresh();
        test_blank_align();
`ifdef COLOR_FX_STATS_EN
        test_stats();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
